// File: rtl/de1_pio_pkg.sv
// Shared constants and helpers for the DE1 parallel input port with interrupt.
package de1_pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam int unsigned EDGE_RISING  = 0;
    localparam int unsigned EDGE_FALLING = 1;
    localparam int unsigned EDGE_ANY     = 2;

    localparam int unsigned IRQ_LEVEL = 0;
    localparam int unsigned IRQ_EDGE  = 1;

    // Bits needed to hold values 0..value-1, never narrower than 1 bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < value) width = i + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/de1_pio_debounce.sv
// One input bit: multi-flop synchroniser followed by an optional stability filter.
module de1_pio_debounce
    import de1_pio_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_pin,
    output logic o_filtered,
    output logic o_filtered_next
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_filtered;
    logic                   w_sync_out;
    logic                   w_filtered_next;

    assign w_sync_out = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_sync <= '0;
        else          r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
    end

    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
        assign w_filtered_next = w_sync_out;
    end else begin : g_filter
        localparam int unsigned    CW   = clog2(DEBOUNCE_CYCLES + 1);
        localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

        logic [CW-1:0] r_count;
        logic          w_differ;
        logic          w_expire;

        assign w_differ        = (w_sync_out != r_filtered);
        assign w_expire        = w_differ && (r_count == LAST);
        assign w_filtered_next = w_expire ? w_sync_out : r_filtered;

        // Any return to agreement restarts the count, so short pulses never land.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)                 r_count <= '0;
            else if (!w_differ || w_expire) r_count <= '0;
            else                          r_count <= r_count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_filtered <= 1'b0;
        else          r_filtered <= w_filtered_next;
    end

    assign o_filtered      = r_filtered;
    assign o_filtered_next = w_filtered_next;

endmodule

// File: rtl/de1_pio_input_irq.sv
// Avalon-MM input port: synchronised/debounced pins, sticky edge capture,
// interrupt mask and level- or edge-driven IRQ.
module de1_pio_input_irq
    import de1_pio_pkg::*;
#(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 0,
    parameter int unsigned EDGE_TYPE       = 0,
    parameter int unsigned IRQ_TYPE        = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] w_filtered;
    logic [WIDTH-1:0] w_filtered_next;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_edge_set;
    logic [WIDTH-1:0] w_clear;
    logic [WIDTH-1:0] r_irq_mask;
    logic [WIDTH-1:0] r_edge_capture;
    logic [31:0]      w_rdata;
    logic             w_wr;
    logic             w_unused_wdata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        de1_pio_debounce #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk             (clk),
            .reset_n         (reset_n),
            .i_pin           (in_port[i]),
            .o_filtered      (w_filtered[i]),
            .o_filtered_next (w_filtered_next[i])
        );
    end

    // The filtered register doubles as the previous value; comparing it with its
    // next value lets edge_capture update on the same clock as the data bit.
    always_comb begin
        w_rise = w_filtered_next & ~w_filtered;
        w_fall = ~w_filtered_next & w_filtered;
        case (EDGE_TYPE)
            EDGE_RISING:  w_edge_set = w_rise;
            EDGE_FALLING: w_edge_set = w_fall;
            default:      w_edge_set = w_rise | w_fall;
        endcase
    end

    assign w_wr           = chipselect && !write_n;
    assign w_clear        = (w_wr && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
    assign w_unused_wdata = &{1'b0, writedata};

    // A new edge outranks a simultaneous write-1-to-clear on the same bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_mask     <= '0;
            r_edge_capture <= '0;
        end else begin
            if (w_wr && address == ADDR_MASK) r_irq_mask <= writedata[WIDTH-1:0];
            r_edge_capture <= (r_edge_capture & ~w_clear) | w_edge_set;
        end
    end

    always_comb begin
        w_rdata = '0;
        case (address)
            ADDR_DATA: w_rdata[WIDTH-1:0] = w_filtered;
            ADDR_MASK: w_rdata[WIDTH-1:0] = r_irq_mask;
            ADDR_EDGE: w_rdata[WIDTH-1:0] = r_edge_capture;
            default:   w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= '0;
        else          readdata <= w_rdata;
    end

    if (IRQ_TYPE == IRQ_LEVEL) begin : g_irq_level
        assign irq = |(w_filtered & r_irq_mask);
    end else begin : g_irq_edge
        assign irq = |(r_edge_capture & r_irq_mask);
    end

endmodule

// File: tb/tb_de1_pio_input_irq.sv
// Bench for de1_pio_input_irq: four instances covering the default build,
// debounce, level IRQ and a 32-bit any-edge build.
module tb_de1_pio_input_irq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  addr [4];
    logic        cs   [4];
    logic        wn   [4];
    logic [31:0] wd   [4];
    logic [31:0] inp  [4];
    logic [31:0] rd   [4];
    logic        irq  [4];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    de1_pio_input_irq #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0), .IRQ_TYPE(1)) u_a (
        .clk(clk), .reset_n(reset_n), .address(addr[0]), .chipselect(cs[0]), .write_n(wn[0]),
        .writedata(wd[0]), .in_port(inp[0][3:0]), .readdata(rd[0]), .irq(irq[0]));

    de1_pio_input_irq #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .EDGE_TYPE(0), .IRQ_TYPE(1)) u_b (
        .clk(clk), .reset_n(reset_n), .address(addr[1]), .chipselect(cs[1]), .write_n(wn[1]),
        .writedata(wd[1]), .in_port(inp[1][3:0]), .readdata(rd[1]), .irq(irq[1]));

    de1_pio_input_irq #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0), .IRQ_TYPE(0)) u_c (
        .clk(clk), .reset_n(reset_n), .address(addr[2]), .chipselect(cs[2]), .write_n(wn[2]),
        .writedata(wd[2]), .in_port(inp[2][3:0]), .readdata(rd[2]), .irq(irq[2]));

    de1_pio_input_irq #(.WIDTH(32), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2), .IRQ_TYPE(1)) u_d (
        .clk(clk), .reset_n(reset_n), .address(addr[3]), .chipselect(cs[3]), .write_n(wn[3]),
        .writedata(wd[3]), .in_port(inp[3]), .readdata(rd[3]), .irq(irq[3]));

    typedef struct {
        int          phase;
        int          dut;
        logic [1:0]  addr;
        logic [31:0] exp;
        string       name;
    } vec_t;

    typedef struct {
        int          dut;
        string       name;
        logic [31:0] exp;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr_reg(input int d, input logic [1:0] a, input logic [31:0] data);
        @(negedge clk);
        addr[d] = a; cs[d] = 1'b1; wn[d] = 1'b0; wd[d] = data;
        @(negedge clk);
        cs[d] = 1'b0; wn[d] = 1'b1;
    endtask

    task automatic rd_reg(input int d, input logic [1:0] a, input logic [31:0] exp, input string name);
        sb_t e;
        @(negedge clk);
        addr[d] = a;
        e.dut = d; e.name = name; e.exp = exp;
        sb_q.push_back(e);
        @(negedge clk);
        e = sb_q.pop_front();
        check(e.name, rd[e.dut], e.exp);
    endtask

    task automatic add_vec(input int p, input int d, input logic [1:0] a, input logic [31:0] exp, input string name);
        vec_t v;
        v.phase = p; v.dut = d; v.addr = a; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic run_phase(input int p);
        foreach (vecs[i]) begin
            if (vecs[i].phase == p) rd_reg(vecs[i].dut, vecs[i].addr, vecs[i].exp, vecs[i].name);
        end
    endtask

    initial begin
        add_vec(1, 0, 2'd0, 32'h0000_000A, "A.data_after_reset");
        add_vec(1, 0, 2'd1, 32'h0000_0000, "A.reserved");
        add_vec(1, 0, 2'd2, 32'h0000_0000, "A.mask_after_reset");
        add_vec(1, 0, 2'd3, 32'h0000_000A, "A.edge_after_reset");
        add_vec(2, 1, 2'd0, 32'h0000_0000, "B.data_glitch7");
        add_vec(2, 1, 2'd3, 32'h0000_0000, "B.edge_glitch7");
        add_vec(3, 1, 2'd3, 32'h0000_0002, "B.edge_pulse8");
        add_vec(3, 1, 2'd0, 32'h0000_0000, "B.data_after_release");
        add_vec(4, 3, 2'd0, 32'hFFFF_FFFF, "D.data_high");
        add_vec(4, 3, 2'd3, 32'hFFFF_FFFF, "D.edge_rise");
        add_vec(5, 3, 2'd0, 32'h0000_0000, "D.data_low");
        add_vec(5, 3, 2'd3, 32'hFFFF_FFFF, "D.edge_fall");
        add_vec(6, 3, 2'd1, 32'h0000_0000, "D.reserved_after_write");
        add_vec(6, 3, 2'd0, 32'h0000_0000, "D.data_after_write");
        add_vec(6, 3, 2'd2, 32'h0000_FFFF, "D.mask_readback");
        add_vec(6, 3, 2'd3, 32'hFFFF_FFFF, "D.edge_unchanged");

        reset_n = 1'b0;
        for (int d = 0; d < 4; d++) begin
            addr[d] = 2'd0; cs[d] = 1'b0; wn[d] = 1'b1; wd[d] = '0; inp[d] = '0;
        end
        inp[0] = 32'hA;

        idle(3);
        check("A.rd_in_reset", rd[0], 32'h0);
        check("A.irq_in_reset", {31'b0, irq[0]}, 32'h0);

        // Reset release, then exact data latency on instance A.
        @(negedge clk);
        reset_n = 1'b1;
        idle(3);
        check("A.data_lat_edge3", rd[0], 32'h0);
        idle(1);
        check("A.data_lat_edge4", rd[0], 32'hA);
        run_phase(1);

        // Edge capture latency and IRQ masking.
        wr_reg(0, 2'd3, 32'hF);
        rd_reg(0, 2'd3, 32'h0, "A.edge_cleared");
        @(negedge clk);
        inp[0] = 32'hB;
        idle(3);
        check("A.edge_lat_edge3", rd[0], 32'h0);
        idle(1);
        check("A.edge_lat_edge4", rd[0], 32'h1);
        check("A.irq_masked", {31'b0, irq[0]}, 32'h0);
        wr_reg(0, 2'd2, 32'h1);
        check("A.irq_unmasked", {31'b0, irq[0]}, 32'h1);
        wr_reg(0, 2'd3, 32'h1);
        check("A.irq_cleared", {31'b0, irq[0]}, 32'h0);

        // Falling edges are ignored in rising mode.
        @(negedge clk);
        inp[0] = 32'hF;
        idle(5);
        wr_reg(0, 2'd3, 32'hF);
        @(negedge clk);
        inp[0] = 32'hB;
        idle(5);
        rd_reg(0, 2'd3, 32'h0, "A.fall_ignored");

        // Clear-write lands on the same edge as a new rising edge on bit2.
        @(negedge clk);
        inp[0] = 32'hF;
        idle(1);
        wr_reg(0, 2'd3, 32'h4);
        rd_reg(0, 2'd3, 32'h4, "A.set_beats_clear");
        wr_reg(0, 2'd3, 32'h4);
        rd_reg(0, 2'd3, 32'h0, "A.clear_bit2");

        // Debounce: 7-cycle pulse rejected, 8-cycle pulse accepted.
        @(negedge clk);
        inp[1] = 32'h2;
        idle(7);
        inp[1] = 32'h0;
        idle(15);
        run_phase(2);
        @(negedge clk);
        inp[1] = 32'h2;
        addr[1] = 2'd0;
        idle(8);
        inp[1] = 32'h0;
        idle(4);
        check("B.data_pulse8", rd[1], 32'h2);
        idle(20);
        run_phase(3);

        // Level IRQ follows filtered data through the mask.
        @(negedge clk);
        inp[2] = 32'h4;
        idle(5);
        check("C.irq_mask0", {31'b0, irq[2]}, 32'h0);
        wr_reg(2, 2'd2, 32'h4);
        check("C.irq_level", {31'b0, irq[2]}, 32'h1);
        @(negedge clk);
        inp[2] = 32'h0;
        idle(2);
        check("C.irq_hold_edge2", {31'b0, irq[2]}, 32'h1);
        idle(1);
        check("C.irq_low_edge3", {31'b0, irq[2]}, 32'h0);

        // 32-bit any-edge instance; writes to data/reserved are ignored.
        @(negedge clk);
        inp[3] = 32'hFFFF_FFFF;
        idle(5);
        run_phase(4);
        check("D.irq_mask0", {31'b0, irq[3]}, 32'h0);
        wr_reg(3, 2'd3, 32'hFFFF_FFFF);
        rd_reg(3, 2'd3, 32'h0, "D.cleared");
        @(negedge clk);
        inp[3] = 32'h0;
        idle(5);
        run_phase(5);
        wr_reg(3, 2'd0, 32'h1234_5678);
        wr_reg(3, 2'd1, 32'hFFFF_FFFF);
        wr_reg(3, 2'd2, 32'h0000_FFFF);
        run_phase(6);
        check("D.irq_edge", {31'b0, irq[3]}, 32'h1);

        // Asynchronous reset in the middle of a read.
        @(negedge clk);
        addr[0] = 2'd0;
        idle(1);
        check("A.data_before_reset", rd[0], 32'hF);
        #2;
        reset_n = 1'b0;
        #1;
        check("A.rd_async_reset", rd[0], 32'h0);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/de1_pio_input_irq.md
Name: de1_pio_input_irq

Overview:
- Parametrised Avalon-MM slave input port: next generation of the DE1 switch/button read port.
- Adds a multi-stage input synchroniser, per-bit debounce filter, edge capture, interrupt mask and IRQ output.
- Sits between board pins (switches, keys) and the Nios II data master; readable via polled reads or interrupt.

Parameters:
- WIDTH, 4, number of input bits (1..32)
- SYNC_STAGES, 2, synchroniser flops per bit (2..4)
- DEBOUNCE_CYCLES, 0, stable cycles required before the filtered bit changes; 0 = bypass
- EDGE_TYPE, 0, edge captured: 0 rising, 1 falling, 2 any
- IRQ_TYPE, 1, 0 level (data & mask), 1 edge (edge_capture & mask)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  2  word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- in_port  in  WIDTH  asynchronous board inputs
- readdata  out  32  registered read data
- irq  out  1  interrupt request, active high

Behaviour:
- Reset: interface is clk with reset_n asynchronous, active-low. All sync flops, filtered bits, previous-filtered bits, debounce counters, irq_mask, edge_capture and readdata clear to 0.
- Register map, reads zero-extended to 32 bits:
  - 0: data, read-only = filtered inputs
  - 1: reserved, reads 0
  - 2: irq_mask, read/write
  - 3: edge_capture, read, write-1-to-clear
- Write occurs when chipselect=1 and write_n=0:
  - addr 2: irq_mask <= writedata[WIDTH-1:0]
  - addr 3: clears bits where writedata is 1
  - addr 0 and addr 1: ignored
- readdata <= mux(address) on every clk edge regardless of chipselect. Read latency is 1 cycle.
- Synchroniser: SYNC_STAGES-deep shift register per bit. sync_out lags in_port by SYNC_STAGES edges.
- Debounce (DEBOUNCE_CYCLES > 0), per bit:
  - sync_out == filtered: counter <= 0
  - otherwise counter increments
  - counter == DEBOUNCE_CYCLES-1 while still differing: filtered <= sync_out, counter <= 0
  - Pulses shorter than DEBOUNCE_CYCLES cycles are rejected.
  - Counter width is clog2(DEBOUNCE_CYCLES+1).
  - DEBOUNCE_CYCLES = 0: filtered <= sync_out each edge.
- Edge detect: prev <= filtered each edge.
  - rise = filtered & ~prev
  - fall = ~filtered & prev
  - Selected edge sets edge_capture bit; bit is sticky until cleared.
- Simultaneous clear-write and new edge on the same bit: set wins, bit stays 1.
- irq is combinational from registers only:
  - IRQ_TYPE 0: |(filtered & irq_mask)
  - IRQ_TYPE 1: |(edge_capture & irq_mask)
- Latency, DEBOUNCE_CYCLES = 0, in_port step settled before edge 1:
  - filtered and edge_capture update at edge SYNC_STAGES+1
  - irq high after edge SYNC_STAGES+1
  - readdata shows it at edge SYNC_STAGES+2
  - Debounce adds DEBOUNCE_CYCLES edges.
- After reset, an input held high produces a rising edge once synchronised. Software clears edge_capture after init.
- Reset mid-debounce discards the count. Reset mid-read returns readdata 0.

Decomposition:
- Package de1_pio_pkg holds:
  - address constants ADDR_DATA=0, ADDR_MASK=2, ADDR_EDGE=3
  - EDGE_RISING/FALLING/ANY and IRQ_LEVEL/IRQ_EDGE constants
  - clog2 function
- Sub-module de1_pio_debounce: one bit, holds synchroniser plus debounce counter; instantiated WIDTH times via generate.
- Top level holds registers, edge logic, read mux and irq.

Test Plan:
- Reset with in_port=4'hA held, DEBOUNCE_CYCLES=0, SYNC_STAGES=2 -> readdata 0 during reset. Read addr 0 after 4 cycles = 0x0000000A. edge_capture = 0xA (rising after reset).
- Write addr 3 = 0xF, then in_port bit0 0->1 -> edge_capture = 0x1 at edge 3 after the step. irq stays 0 with mask 0. Write addr 2 = 0x1 -> irq=1. Write addr 3 = 0x1 -> irq=0 next cycle.
- DEBOUNCE_CYCLES=8, bit1 glitch high for 7 cycles -> data bit1 stays 0, no capture. Glitch high for 8 cycles -> bit1=1, edge_capture bit1=1.
- Same-cycle clear-write to bit2 and new rising edge on bit2 -> edge_capture bit2 remains 1.
- IRQ_TYPE=0, mask=0x4, in_port=0x4 -> irq=1. in_port=0x0 -> irq=0 after SYNC_STAGES+1 edges.
- WIDTH=32, EDGE_TYPE=2, toggle all bits -> edge_capture = 0xFFFFFFFF on both edges. Writes to addr 0 and 1 leave state unchanged; addr 1 reads 0.
